// File: rtl/poly_mixer.sv
// N-channel voice mixer: snapshots all channels, sums the non-zero ones serially, then divides by the active count.
// Optional build macro MIXER_ROUND_EN selects round-half-up with saturation instead of floor division.
module poly_mixer #(
    parameter  int N_CH  = 13,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(N_CH + 1),
    localparam int SUM_W = WIDTH + $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_CH*WIDTH-1:0]   notes,
    output logic [WIDTH-1:0]        sample,
    output logic [CNT_W-1:0]        active_cnt,
    output logic                    busy,
    output logic                    done
);

`ifdef MIXER_ROUND_EN
    localparam int ACC_W = SUM_W + 1;
`else
    localparam int ACC_W = SUM_W;
`endif
    localparam int IDX_W = $clog2(N_CH);
    localparam int REM_W = CNT_W + 1;
    localparam int BIT_W = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DIV   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [N_CH*WIDTH-1:0]   snap_q;
    logic [ACC_W-1:0]        acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [SUM_W-1:0]        div_q;
    logic [CNT_W-1:0]        rem_q;
    logic [BIT_W-1:0]        bit_q;
    logic [WIDTH-1:0]        sample_q;
    logic [CNT_W-1:0]        active_cnt_q;
    logic                    busy_q;
    logic                    done_q;

    logic [WIDTH-1:0]        chan_s;
    logic                    nz_s;
    logic [ACC_W-1:0]        acc_d;
    logic [CNT_W-1:0]        cnt_d;
    logic [SUM_W-1:0]        dividend_s;
    logic [REM_W-1:0]        rem_shift_s;
    logic                    rem_ge_s;
    logic [CNT_W-1:0]        rem_d;
    logic [SUM_W-1:0]        div_d;
    logic [WIDTH-1:0]        quot_s;
`ifdef MIXER_ROUND_EN
    logic [ACC_W-1:0]        rnd_s;
`endif

    // The snapshot shifts right each ACCUM cycle, so the current channel is always the low slice.
    always_comb begin
        chan_s = snap_q[WIDTH-1:0];
        nz_s   = (chan_s != {WIDTH{1'b0}});
        if (nz_s) begin
            acc_d = acc_q + ACC_W'(chan_s);
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Dividend loaded on entry to DIV; the rounded form still fits SUM_W bits since the bias is below N_CH.
    always_comb begin
`ifdef MIXER_ROUND_EN
        rnd_s      = acc_d + ACC_W'(cnt_d >> 1);
        dividend_s = rnd_s[SUM_W-1:0];
`else
        dividend_s = acc_d;
`endif
    end

    // One restoring-division step: shift in the dividend MSB, subtract divisor if it fits.
    always_comb begin
        rem_shift_s = {rem_q, div_q[SUM_W-1]};
        rem_ge_s    = (rem_shift_s >= {1'b0, cnt_q});
        if (rem_ge_s) begin
            rem_d = CNT_W'(rem_shift_s - {1'b0, cnt_q});
        end else begin
            rem_d = rem_shift_s[CNT_W-1:0];
        end
        div_d = {div_q[SUM_W-2:0], rem_ge_s};
    end

    // Final quotient narrowed to the output width.
    always_comb begin
`ifdef MIXER_ROUND_EN
        if (|div_q[SUM_W-1:WIDTH]) begin
            quot_s = {WIDTH{1'b1}};
        end else begin
            quot_s = div_q[WIDTH-1:0];
        end
`else
        quot_s = div_q[WIDTH-1:0];
`endif
    end

    // Mixer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            snap_q       <= {(N_CH*WIDTH){1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            div_q        <= {SUM_W{1'b0}};
            rem_q        <= {CNT_W{1'b0}};
            bit_q        <= {BIT_W{1'b0}};
            sample_q     <= {WIDTH{1'b0}};
            active_cnt_q <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        snap_q  <= notes;
                        acc_q   <= {ACC_W{1'b0}};
                        cnt_q   <= {CNT_W{1'b0}};
                        idx_q   <= {IDX_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= S_ACCUM;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACCUM: begin
                    acc_q  <= acc_d;
                    cnt_q  <= cnt_d;
                    snap_q <= snap_q >> WIDTH;
                    if (idx_q == IDX_W'(N_CH - 1)) begin
                        rem_q <= {CNT_W{1'b0}};
                        bit_q <= {BIT_W{1'b0}};
                        if (cnt_d == {CNT_W{1'b0}}) begin
                            div_q   <= {SUM_W{1'b0}};
                            state_q <= S_DONE;
                        end else begin
                            div_q   <= dividend_s;
                            state_q <= S_DIV;
                        end
                    end else begin
                        idx_q <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DIV: begin
                    div_q <= div_d;
                    rem_q <= rem_d;
                    bit_q <= bit_q + {{(BIT_W-1){1'b0}}, 1'b1};
                    if (bit_q == BIT_W'(SUM_W - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_DONE: begin
                    sample_q     <= quot_s;
                    active_cnt_q <= cnt_q;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sample     = sample_q;
    assign active_cnt = active_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
